display_in: RTL and testbench
=============================

// Module: display_in
// PURPOSE
//  Receive end of the serial 7-segment display link. Deserialises the 32-bit
//  LSB-first segment word framed by a sync strobe, decodes the four segment
//  bytes back to BCD digits, checks frame spacing, and presents the result
//  through a valid/ready handshake. Loop-back checker and remote-display input.
// PARAMETERS
//  FRAME_PERIOD  35  enabled cycles from one frame_sync to the next
//  CNT_W         8   width of the gap counter; saturates at 2**CNT_W-1
// PORTS
//  clk         in   1   system clock; all sampling on posedge
//  rst         in   1   asynchronous, active-low reset
//  enable      in   1   bit-slot qualifier; all receive state frozen when 0
//  data_in     in   1   serial segment data, one bit per enabled cycle, LSB first
//  frame_sync  in   1   high for one enabled cycle right after bit 31 of a frame
//  bcd_out     out  16  decoded digits {d3,d2,d1,d0}; d3 from word[31:24]
//  digit_err   out  4   per digit: segment byte not a 0..9 pattern
//  frame_err   out  1   captured frame had bad spacing or too few bits
//  out_valid   out  1   bcd_out/digit_err/frame_err hold a frame
//  out_ready   in   1   consumer accepts on out_valid && out_ready
//  overrun     out  1   1-cycle pulse: unconsumed frame overwritten
// BEHAVIOUR
//  Reset (rst=0, async): sr, gap_cnt, locked, all outputs = 0.
//  Shift: enable && !frame_sync -> sr <= {data_in, sr[31:1]}; gap_cnt++ (sat).
//   After 32 shifts, sr[0] = first bit received = word bit 0.
//  Capture: enable && frame_sync, on that posedge:
//   - bcd_out/digit_err <= decode(sr); frame_err per rule below; out_valid <= 1
//   - gap_cnt <= 0; locked <= 1; sr not shifted (sync cycle carries no data)
//   - outputs visible the cycle after the sync-sampling edge (latency 1).
//  frame_err: !locked -> (gap_cnt < 32); locked -> (gap_cnt != FRAME_PERIOD-1).
//   Data is still captured and decoded on frame_err.
//  Decode per byte: FC->0 60->1 DA->2 F2->3 66->4 B6->5 BE->6 E0->7 FE->8
//   F6->9; any other byte (incl. dash 02) -> nibble 4'hF and digit_err bit set.
//  Handshake (independent of enable):
//   - out_valid && out_ready && !capture -> out_valid <= 0; data regs hold.
//   - capture && (!out_valid || out_ready) -> load, out_valid stays 1, no overrun.
//   - capture && out_valid && !out_ready -> overwrite, overrun=1 for one cycle.
//   - overrun is 0 in every other cycle.
//  enable=0: sr, gap_cnt, locked frozen; frame_sync and data_in ignored.
//  Gap cycles between frames shift junk into sr; it is flushed by the next
//   32 data bits, so no special handling.
//  Reset mid-frame: partial frame discarded, locked=0, out_valid drops at once.
//  Output regs change only on capture or reset.
// TESTING
//  T1 enable=1; send word 0x60DAF266 (BCD 1234) LSB first, sync after bit 31,
//     ready=1 -> next cycle bcd_out=16'h1234, digit_err=0, frame_err=0, valid=1.
//  T2 two back-to-back frames 35 cycles apart, 2nd = BCD 9087 ->
//     bcd_out=16'h9087, frame_err=0; shorten spacing to 34 -> frame_err=1.
//  T3 word 0x02FC6060 (dash,0,1,1) -> bcd_out=16'hF011, digit_err=4'b1000.
//  T4 out_ready=0, two frames -> 2nd overwrites, overrun pulses exactly 1
//     cycle; then ready=1 -> valid drops next cycle; capture+ready same cycle
//     -> no overrun, valid stays 1.
//  T5 enable toggled 0 for 5 cycles mid-frame -> result identical to T1;
//     frame_sync while enable=0 -> no capture.
//  T6 rst=0 asserted mid-frame, async (between clock edges) -> all outputs 0
//     immediately; first sync after only 20 bits -> frame_err=1.

Source files
------------

// File: rtl/display_in.sv
// Receive end of the serial 7-segment link: deserialises LSB-first segment words,
// decodes them to BCD, checks frame spacing and offers the result on valid/ready.
module display_in #(
    parameter int FRAME_PERIOD = 35,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        data_in,
    input  logic        frame_sync,
    output logic [15:0] bcd_out,
    output logic [3:0]  digit_err,
    output logic        frame_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] GAP_MAX   = '1;
    localparam logic [CNT_W-1:0] GAP_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_BITS  = CNT_W'(32);
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(FRAME_PERIOD - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hs_state_t;

    hs_state_t        state_reg, state_next;
    logic [31:0]      sr_reg, sr_next;
    logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             locked_reg, locked_next;
    logic [15:0]      bcd_reg, bcd_next;
    logic [3:0]       derr_reg, derr_next;
    logic             ferr_reg, ferr_next;
    logic             overrun_reg, overrun_next;

    logic             capture;
    logic             shift_en;
    logic             spacing_bad;
    logic [15:0]      dec_bcd;
    logic [3:0]       dec_err;

    // Returns {error, nibble}; unknown patterns (including the dash) map to F.
    function automatic logic [4:0] decode_seg(input logic [7:0] seg);
        case (seg)
            8'hFC:   return 5'h00;
            8'h60:   return 5'h01;
            8'hDA:   return 5'h02;
            8'hF2:   return 5'h03;
            8'h66:   return 5'h04;
            8'hB6:   return 5'h05;
            8'hBE:   return 5'h06;
            8'hE0:   return 5'h07;
            8'hFE:   return 5'h08;
            8'hF6:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            logic [4:0] dec;
            assign dec                = decode_seg(sr_reg[gi*8 +: 8]);
            assign dec_bcd[gi*4 +: 4] = dec[3:0];
            assign dec_err[gi]        = dec[4];
        end
    endgenerate

    assign capture  = enable && frame_sync;
    assign shift_en = enable && !frame_sync;

    // Before the first sync we only know whether enough bits arrived;
    // once locked the spacing must be exact.
    assign spacing_bad = locked_reg ? (gap_cnt_reg != PERIOD_M1)
                                    : (gap_cnt_reg < MIN_BITS);

    always_comb begin
        sr_next      = sr_reg;
        gap_cnt_next = gap_cnt_reg;
        locked_next  = locked_reg;
        bcd_next     = bcd_reg;
        derr_next    = derr_reg;
        ferr_next    = ferr_reg;
        state_next   = state_reg;
        overrun_next = 1'b0;

        if (shift_en) begin
            sr_next = {data_in, sr_reg[31:1]};
            if (gap_cnt_reg != GAP_MAX)
                gap_cnt_next = gap_cnt_reg + GAP_ONE;
        end

        if (capture) begin
            gap_cnt_next = '0;
            locked_next  = 1'b1;
            bcd_next     = dec_bcd;
            derr_next    = dec_err;
            ferr_next    = spacing_bad;
            state_next   = ST_FULL;
            overrun_next = (state_reg == ST_FULL) && !out_ready;
        end else if (state_reg == ST_FULL && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_EMPTY;
            sr_reg      <= '0;
            gap_cnt_reg <= '0;
            locked_reg  <= 1'b0;
            bcd_reg     <= '0;
            derr_reg    <= '0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            gap_cnt_reg <= gap_cnt_next;
            locked_reg  <= locked_next;
            bcd_reg     <= bcd_next;
            derr_reg    <= derr_next;
            ferr_reg    <= ferr_next;
            overrun_reg <= overrun_next;
        end
    end

    assign bcd_out   = bcd_reg;
    assign digit_err = derr_reg;
    assign frame_err = ferr_reg;
    assign out_valid = (state_reg == ST_FULL);
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_display_in.sv
// Directed bench for display_in: frames are encoded from digits, expectations
// queued at the sync cycle and checked the cycle after capture.
module tb_display_in;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        data_in;
    logic        frame_sync;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_err;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    display_in #(.FRAME_PERIOD(35), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .frame_sync (frame_sync),
        .bcd_out    (bcd_out),
        .digit_err  (digit_err),
        .frame_err  (frame_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  derr;
        logic        ferr;
        logic        ovr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hFC;
            1: return 8'h60;
            2: return 8'hDA;
            3: return 8'hF2;
            4: return 8'h66;
            5: return 8'hB6;
            6: return 8'hBE;
            7: return 8'hE0;
            8: return 8'hFE;
            default: return 8'hF6;
        endcase
    endfunction

    function automatic logic [31:0] mkword(input int d3, input int d2, input int d1, input int d0);
        return {seg_of(d3), seg_of(d2), seg_of(d1), seg_of(d0)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        enable     = 1'b1;
        frame_sync = 1'b0;
        data_in    = b;
        tick();
    endtask

    // Sync cycle: push the expectation, capture, then pop and compare.
    task automatic do_sync(input exp_t e, input logic rdy_sync, input string tag);
        exp_t got;
        sb.push_back(e);
        out_ready  = rdy_sync;
        enable     = 1'b1;
        frame_sync = 1'b1;
        data_in    = 1'($urandom_range(0, 1));
        tick();
        frame_sync = 1'b0;
        got = sb.pop_front();
        chk({tag, ".bcd"},  32'(bcd_out),   32'(got.bcd));
        chk({tag, ".derr"}, 32'(digit_err), 32'(got.derr));
        chk({tag, ".ferr"}, 32'(frame_err), 32'(got.ferr));
        chk({tag, ".vld"},  32'(out_valid), 32'd1);
        chk({tag, ".ovr"},  32'(overrun),   32'(got.ovr));
        $display("frame %s: bcd=%h derr=%b ferr=%b ovr=%b", tag, bcd_out, digit_err, frame_err, overrun);
    endtask

    // Five disabled cycles with a frame_sync pulse that must be ignored.
    task automatic stall(input string tag);
        for (int k = 0; k < 5; k++) begin
            enable     = 1'b0;
            frame_sync = (k == 2);
            data_in    = 1'($urandom_range(0, 1));
            tick();
        end
        frame_sync = 1'b0;
        chk({tag, ".nocap"}, 32'(out_valid), 32'd0);
    endtask

    task automatic send_frame(input logic [31:0] word, input logic [15:0] ebcd,
                              input logic [3:0] ederr, input int gap, input logic eferr,
                              input logic eovr, input logic rdy_bits, input logic rdy_sync,
                              input int stall_at, input string tag);
        exp_t e;
        out_ready = rdy_bits;
        for (int k = 0; k < gap; k++) drive_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) begin
            if (i == stall_at) stall(tag);
            drive_bit(word[i]);
        end
        e.bcd  = ebcd;
        e.derr = ederr;
        e.ferr = eferr;
        e.ovr  = eovr;
        do_sync(e, rdy_sync, tag);
    endtask

    initial begin
        logic [19:0] part;
        exp_t        e;

        rst        = 1'b0;
        enable     = 1'b0;
        data_in    = 1'b0;
        frame_sync = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst.bcd",  32'(bcd_out),   32'd0);
        chk("rst.derr", 32'(digit_err), 32'd0);
        chk("rst.ferr", 32'(frame_err), 32'd0);
        chk("rst.vld",  32'(out_valid), 32'd0);
        chk("rst.ovr",  32'(overrun),   32'd0);
        rst = 1'b1;
        tick();

        // T1: first frame after reset, exactly 32 bits
        send_frame(mkword(1, 2, 3, 4), 16'h1234, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, "t1");

        // T2: correct spacing, then one cycle short
        send_frame(mkword(9, 0, 8, 7), 16'h9087, 4'b0000, 2, 1'b0, 1'b0, 1'b1, 1'b1, -1, "t2a");
        send_frame(mkword(5, 6, 7, 8), 16'h5678, 4'b0000, 1, 1'b1, 1'b0, 1'b1, 1'b1, -1, "t2b");

        // T3: dash in the top digit
        send_frame(32'h02FC6060, 16'hF011, 4'b1000, 2, 1'b0, 1'b0, 1'b1, 1'b1, -1, "t3");

        // T4: backpressure, overrun and simultaneous capture/accept
        send_frame(mkword(2, 4, 6, 8), 16'h2468, 4'b0000, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1, "t4a");
        send_frame(mkword(1, 3, 5, 7), 16'h1357, 4'b0000, 2, 1'b0, 1'b1, 1'b0, 1'b0, -1, "t4b");
        drive_bit(1'b1);
        chk("t4.ovr_pulse", 32'(overrun),   32'd0);
        chk("t4.vld_hold",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drive_bit(1'b0);
        chk("t4.vld_drop",  32'(out_valid), 32'd0);
        chk("t4.bcd_hold",  32'(bcd_out),   32'h1357);
        send_frame(mkword(4, 0, 9, 6), 16'h4096, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "t4c");
        send_frame(mkword(7, 5, 3, 1), 16'h7531, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 1'b1, -1, "t4d");

        // T5: enable gap mid-frame with an ignored sync inside it
        send_frame(mkword(1, 2, 3, 4), 16'h1234, 4'b0000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16, "t5");

        // T6: asynchronous reset mid-frame, then a short first frame
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) drive_bit(1'($urandom_range(0, 1)));
        chk("t6.pre_vld", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6.async_bcd",  32'(bcd_out),   32'd0);
        chk("t6.async_derr", 32'(digit_err), 32'd0);
        chk("t6.async_ferr", 32'(frame_err), 32'd0);
        chk("t6.async_vld",  32'(out_valid), 32'd0);
        chk("t6.async_ovr",  32'(overrun),   32'd0);
        enable = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        part = {seg_of(5), seg_of(8), 4'h6};
        for (int i = 0; i < 20; i++) drive_bit(part[i]);
        e.bcd  = 16'h581F;
        e.derr = 4'b0001;
        e.ferr = 1'b1;
        e.ovr  = 1'b0;
        do_sync(e, 1'b1, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
